// File: rtl/tr_seq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tr_seq_pkg : shared encodings for the TR sequencer                   |
// | Rev 1.0    : initial release                                         |
// +----------------------------------------------------------------------+
package tr_seq_pkg;

  localparam int TR_W      = 9;
  localparam int CNT_W_DEF = 4;

  localparam logic [1:0] OP_CLEAR  = 2'b00;
  localparam logic [1:0] OP_LOAD_A = 2'b01;
  localparam logic [1:0] OP_LOAD_B = 2'b10;
  localparam logic [1:0] OP_SHIFT  = 2'b11;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CLR   = 3'd1;
  localparam logic [2:0] ST_XFER  = 3'd2;
  localparam logic [2:0] ST_SHIFT = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

endpackage
`default_nettype wire

// File: rtl/tr_seq_arb.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tr_seq_arb : CPU-first arbiter with IO starvation guard              |
// | Rev 1.0    : initial release                                         |
// +----------------------------------------------------------------------+
module tr_seq_arb #(
  parameter int STARVE_LIM = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic cpu_req,
  input  logic io_req,
  output logic grant_cpu,
  output logic grant_io
);

  logic [2:0] r_starve;
  logic       w_io_wins;

  always_comb begin
    w_io_wins = io_req & (~cpu_req | (r_starve == 3'(STARVE_LIM)));
    grant_io  = en & w_io_wins;
    grant_cpu = en & cpu_req & ~w_io_wins;
  end

  // Counter cannot pass STARVE_LIM: at the limit a pending IO always wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve <= 3'd0;
    end else if (grant_io) begin
      r_starve <= 3'd0;
    end else if (grant_cpu) begin
      r_starve <= io_req ? (r_starve + 3'd1) : 3'd0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/tr_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tr_sequencer : arbitrates CPU/IO and sequences TR control strobes    |
// | Option macro : TRSEQ_ZSTOP_EN (early shift stop on TR == 0)           |
// | Rev 1.0      : initial release                                       |
// +----------------------------------------------------------------------+
module tr_sequencer
  import tr_seq_pkg::*;
#(
  parameter int STARVE_LIM = 3,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cpu_req,
  input  logic [1:0]       cpu_op,
  input  logic [CNT_W-1:0] cpu_cnt,
  input  logic             io_req,
  input  logic [1:0]       io_op,
  input  logic [CNT_W-1:0] io_cnt,
  input  logic [TR_W-1:0]  tr_in,
  output logic             cpu_ack,
  output logic             io_ack,
  output logic             busy,
  output logic             done,
  output logic             done_io,
  output logic             zstop,
  output logic             cltr,
  output logic             tbr,
  output logic             maov,
  output logic             mbov,
  output logic             srtr
);

  logic [2:0]       r_state, w_next;
  logic [1:0]       r_op, w_op;
  logic [CNT_W-1:0] r_cnt, w_cnt;
  logic             r_owner, w_owner;
  logic             w_idle, w_grant_cpu, w_grant_io, w_zero;

  logic r_cpu_ack, r_io_ack, r_busy, r_done, r_done_io, r_zstop;
  logic r_cltr, r_tbr, r_maov, r_mbov, r_srtr;
  logic w_cpu_ack_n, w_io_ack_n, w_busy_n, w_done_n, w_done_io_n, w_zstop_n;
  logic w_cltr_n, w_tbr_n, w_maov_n, w_mbov_n, w_srtr_n;

  assign w_idle = (r_state == ST_IDLE);

  tr_seq_arb #(.STARVE_LIM(STARVE_LIM)) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (w_idle),
    .cpu_req   (cpu_req),
    .io_req    (io_req),
    .grant_cpu (w_grant_cpu),
    .grant_io  (w_grant_io)
  );

  assign w_op  = w_grant_io ? io_op  : cpu_op;
  assign w_cnt = w_grant_io ? io_cnt : cpu_cnt;

`ifdef TRSEQ_ZSTOP_EN
  assign w_zero = (r_state == ST_SHIFT) && (tr_in == '0);
`else
  logic w_unused_tr;
  assign w_unused_tr = ^tr_in;
  assign w_zero      = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_grant_cpu | w_grant_io) begin
          if (w_op == OP_SHIFT) w_next = (w_cnt == '0) ? ST_DONE : ST_SHIFT;
          else                  w_next = ST_CLR;
        end
      end
      ST_CLR:   w_next = (r_op == OP_CLEAR) ? ST_DONE : ST_XFER;
      ST_XFER:  w_next = ST_DONE;
      ST_SHIFT: if (w_zero || (r_cnt == CNT_W'(1))) w_next = ST_DONE;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Operands latch at grant; r_cnt then counts remaining shift cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op    <= OP_CLEAR;
      r_cnt   <= '0;
      r_owner <= 1'b0;
    end else if (w_grant_cpu | w_grant_io) begin
      r_op    <= w_op;
      r_cnt   <= w_cnt;
      r_owner <= w_grant_io;
    end else if (r_state == ST_SHIFT) begin
      r_cnt   <= r_cnt - CNT_W'(1);
    end
  end

  always_comb begin
    w_owner     = w_idle ? w_grant_io : r_owner;
    w_cpu_ack_n = w_grant_cpu;
    w_io_ack_n  = w_grant_io;
    w_busy_n    = (w_next != ST_IDLE);
    w_done_n    = (w_next == ST_DONE);
    w_done_io_n = w_done_n & w_owner;
    w_zstop_n   = w_zero;
    w_cltr_n    = (w_next == ST_CLR);
    w_tbr_n     = (w_next == ST_XFER);
    w_maov_n    = w_tbr_n & (r_op == OP_LOAD_A);
    w_mbov_n    = w_tbr_n & (r_op == OP_LOAD_B);
    w_srtr_n    = (w_next == ST_SHIFT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cpu_ack <= 1'b0;
      r_io_ack  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_done_io <= 1'b0;
      r_zstop   <= 1'b0;
      r_cltr    <= 1'b0;
      r_tbr     <= 1'b0;
      r_maov    <= 1'b0;
      r_mbov    <= 1'b0;
      r_srtr    <= 1'b0;
    end else begin
      r_cpu_ack <= w_cpu_ack_n;
      r_io_ack  <= w_io_ack_n;
      r_busy    <= w_busy_n;
      r_done    <= w_done_n;
      r_done_io <= w_done_io_n;
      r_zstop   <= w_zstop_n;
      r_cltr    <= w_cltr_n;
      r_tbr     <= w_tbr_n;
      r_maov    <= w_maov_n;
      r_mbov    <= w_mbov_n;
      r_srtr    <= w_srtr_n;
    end
  end

  assign cpu_ack = r_cpu_ack;
  assign io_ack  = r_io_ack;
  assign busy    = r_busy;
  assign done    = r_done;
  assign done_io = r_done_io;
  assign zstop   = r_zstop;
  assign cltr    = r_cltr;
  assign tbr     = r_tbr;
  assign maov    = r_maov;
  assign mbov    = r_mbov;
  // A zero TR suppresses the strobe already scheduled for this cycle.
  assign srtr    = r_srtr & ~w_zero;

endmodule
`default_nettype wire

// File: tb/tb_tr_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_tr_sequencer : transaction-level model bench for tr_sequencer     |
// | Rev 1.0         : initial release                                    |
// +----------------------------------------------------------------------+
module tb_tr_sequencer;

  localparam int STARVE_LIM = 3;
  localparam logic [1:0] CLEAR = 2'b00, LOAD_A = 2'b01, LOAD_B = 2'b10, SHIFT = 2'b11;

  logic clk, rst_n;
  logic cpu_req, io_req;
  logic [1:0] cpu_op, io_op;
  logic [3:0] cpu_cnt, io_cnt;
  logic [8:0] tr_in;
  logic cpu_ack, io_ack, busy, done, done_io, zstop, cltr, tbr, maov, mbov, srtr;

  tr_sequencer #(.STARVE_LIM(STARVE_LIM), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_op(cpu_op), .cpu_cnt(cpu_cnt),
    .io_req(io_req), .io_op(io_op), .io_cnt(io_cnt), .tr_in(tr_in),
    .cpu_ack(cpu_ack), .io_ack(io_ack), .busy(busy), .done(done), .done_io(done_io),
    .zstop(zstop), .cltr(cltr), .tbr(tbr), .maov(maov), .mbov(mbov), .srtr(srtr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic cack, iack, busy, done, dio, zs, cltr, tbr, maov, mbov, srtr, sh;
  } vec_t;

  int   checks = 0, errors = 0;
  vec_t q[$];
  vec_t exp_v;
  int   m_starve = 0;
  bit   m_owner  = 1'b0;
  int   srtr_tot = 0, done_tot = 0;
  bit   glog[$];
  logic [10:0] act_v;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic vec_t donev(input bit w, input bit zs);
    vec_t v;
    v = '0; v.busy = 1'b1; v.done = 1'b1; v.dio = w; v.zs = zs;
    return v;
  endfunction

  // Expected per-cycle output vectors for one granted operation.
  task automatic build(input bit w, input logic [1:0] op, input int cnt);
    vec_t a, v;
    a = '0; a.cack = ~w; a.iack = w; a.busy = 1'b1;
    if (op == SHIFT) begin
      if (cnt == 0) begin
        v = donev(w, 1'b0); v.cack = ~w; v.iack = w; q.push_back(v);
      end else begin
        for (int i = 0; i < cnt; i++) begin
          v = (i == 0) ? a : vec_t'(0);
          v.busy = 1'b1; v.srtr = 1'b1; v.sh = 1'b1;
          q.push_back(v);
        end
        q.push_back(donev(w, 1'b0));
      end
    end else begin
      a.cltr = 1'b1; q.push_back(a);
      if (op != CLEAR) begin
        v = '0; v.busy = 1'b1; v.tbr = 1'b1;
        v.maov = (op == LOAD_A); v.mbov = (op == LOAD_B);
        q.push_back(v);
      end
      q.push_back(donev(w, 1'b0));
    end
    q.push_back(vec_t'(0));
  endtask

  // Model advance: an empty queue means the previous cycle was idle.
  always @(posedge clk) begin : model
    bit w;
    if (!rst_n) begin
      q.delete(); exp_v = '0; m_starve = 0;
    end else if (q.size() == 0) begin
      if (cpu_req || io_req) begin
        w = io_req && (!cpu_req || m_starve == STARVE_LIM);
        if (w) m_starve = 0;
        else   m_starve = io_req ? m_starve + 1 : 0;
        m_owner = w;
        build(w, w ? io_op : cpu_op, w ? int'(io_cnt) : int'(cpu_cnt));
        exp_v = q.pop_front();
      end else begin
        exp_v = '0;
      end
    end else begin
      exp_v = q.pop_front();
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete(); exp_v = '0; m_starve = 0;
    end
`ifdef TRSEQ_ZSTOP_EN
    if (exp_v.sh && tr_in == 9'h000) begin
      exp_v.srtr = 1'b0; exp_v.sh = 1'b0;
      q.delete();
      q.push_back(donev(m_owner, 1'b1));
      q.push_back(vec_t'(0));
    end
`endif
    act_v = {cpu_ack, io_ack, busy, done, done_io, zstop, cltr, tbr, maov, mbov, srtr};
    chk("cycle_outputs", 32'(act_v), 32'(exp_v[11:1]));
    if (srtr) srtr_tot++;
    if (done) done_tot++;
    if (cpu_ack) glog.push_back(1'b0);
    if (io_ack)  glog.push_back(1'b1);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; cpu_req = 1'b0; io_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Raise a request, return in its ACK cycle with the request dropped.
  task automatic txn(input bit w, input logic [1:0] op, input logic [3:0] cnt, output int lat);
    bit got;
    got = 1'b0; lat = 0;
    if (w) begin io_req = 1'b1; io_op = op; io_cnt = cnt; end
    else   begin cpu_req = 1'b1; cpu_op = op; cpu_cnt = cnt; end
    for (int i = 0; i < 200; i++) begin
      tick();
      lat = i + 1;
      if (w ? io_ack : cpu_ack) begin got = 1'b1; break; end
    end
    chk(w ? "io_ack_seen" : "cpu_ack_seen", 32'(got), 32'd1);
    if (w) io_req = 1'b0; else cpu_req = 1'b0;
  endtask

  task automatic wait_done();
    bit got;
    got = done;
    for (int i = 0; i < 30 && !got; i++) begin
      tick();
      got = done;
    end
    chk("done_seen", 32'(got), 32'd1);
  endtask

  task automatic rand_requester(input bit w, input int n);
    int lat;
    for (int k = 0; k < n; k++) begin
      repeat ($urandom_range(0, 3)) tick();
      txn(w, 2'($urandom_range(0, 3)), 4'($urandom_range(0, 12)), lat);
      tick();
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, required finish");
    $fatal(1);
  end

  initial begin : main
    int lat, s0, d0, g0;
    bit stop;
    cpu_op = CLEAR; cpu_cnt = '0; io_op = CLEAR; io_cnt = '0; tr_in = 9'h1ff;
    do_reset();

    // Reset and CPU LOAD_A timing
    chk("reset_outputs",
        32'({cpu_ack, io_ack, busy, done, done_io, zstop, cltr, tbr, maov, mbov, srtr}), 32'd0);
    txn(1'b0, LOAD_A, 4'd0, lat);
    chk("load_ack_latency", 32'(lat), 32'd1);
    chk("load_t1_cltr_busy", 32'({cltr, busy, tbr}), 32'b110);
    tick();
    chk("load_t2_tbr_maov", 32'({cltr, tbr, maov, mbov}), 32'b0110);
    tick();
    chk("load_t3_done", 32'({done, done_io, busy}), 32'b101);

    // IO SHIFT 5
    do_reset();
    s0 = srtr_tot;
    txn(1'b1, SHIFT, 4'd5, lat);
    for (int i = 0; i < 5; i++) begin
      chk("shift5_srtr_run", 32'({srtr, done}), 32'b10);
      if (i < 4) tick();
    end
    tick();
    chk("shift5_done_io", 32'({done, done_io}), 32'b11);
    chk("shift5_pulses", 32'(srtr_tot - s0), 32'd5);

    // Starvation ordering with both requesters re-raising
    do_reset();
    g0 = glog.size();
    fork
      begin for (int k = 0; k < 4; k++) begin txn(1'b0, CLEAR, 4'd0, lat); tick(); end end
      begin for (int k = 0; k < 2; k++) begin txn(1'b1, CLEAR, 4'd0, lat); tick(); end end
    join
    repeat (4) tick();
    chk("grant_count", 32'(glog.size() - g0), 32'd6);
    if (glog.size() - g0 >= 5)
      chk("grant_order", 32'({glog[g0], glog[g0+1], glog[g0+2], glog[g0+3], glog[g0+4]}),
          32'b00010);

    // SHIFT CNT=0 bypass
    do_reset();
    s0 = srtr_tot;
    txn(1'b0, SHIFT, 4'd0, lat);
    chk("shift0_ack_done", 32'({cpu_ack, done, done_io, srtr}), 32'b1100);
    repeat (3) tick();
    chk("shift0_no_srtr", 32'(srtr_tot - s0), 32'd0);

    // Reset during SHIFT cycle 3 of 8
    do_reset();
    txn(1'b0, SHIFT, 4'd8, lat);
    tick(); tick();
    chk("abort_c3_srtr", 32'(srtr), 32'd1);
    d0 = done_tot;
    rst_n = 1'b0;
    #1;
    chk("abort_outputs_zero",
        32'({cpu_ack, io_ack, busy, done, done_io, zstop, cltr, tbr, maov, mbov, srtr}), 32'd0);
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    chk("abort_no_done", 32'(done_tot - d0), 32'd0);
    chk("abort_idle", 32'(busy), 32'd0);

    // SHIFT 9 with TR forced to zero after two strobes
    do_reset();
    tr_in = 9'h1ff;
    s0 = srtr_tot;
    txn(1'b0, SHIFT, 4'd9, lat);
    tick(); tick();
    tr_in = 9'h000;
    wait_done();
`ifdef TRSEQ_ZSTOP_EN
    chk("zstop_pulses", 32'(srtr_tot - s0), 32'd2);
    chk("zstop_flag", 32'(zstop), 32'd1);
`else
    chk("zstop_pulses", 32'(srtr_tot - s0), 32'd9);
    chk("zstop_flag", 32'(zstop), 32'd0);
`endif
    tick();

    // Randomized traffic from both requesters
    do_reset();
    stop = 1'b0;
    fork
      begin
        fork
          rand_requester(1'b0, 40);
          rand_requester(1'b1, 40);
        join
        stop = 1'b1;
      end
      begin
        while (!stop) begin
          tick();
          tr_in = ($urandom_range(0, 5) == 0) ? 9'h000 : 9'($urandom_range(1, 511));
        end
      end
    join
    repeat (20) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
